// File: rtl/adpcm_main_prod_accum_if.sv
// adpcm_main_prod_accum_if
//   Bundles the product-stream input and the result output of the ADPCM
//   predictor dot-product accumulator.
//
//   Signals (direction as seen by the accumulator, i.e. the slave modport):
//     ce        in   shared clock enable with the upstream multiplier
//     start     in   begin a new accumulation (honoured only when idle)
//     din       in   signed product from the multiplier
//     din_vld   in   din carries a term this cycle
//     dout      out  saturated, shifted sum
//     dout_vld  out  one-cycle (ce-qualified) result pulse
//     busy      out  accumulation in progress
//     sat       out  current dout was clipped
//
//   Handshake: there is no ready/backpressure path. din_vld is a pure
//   valid qualifier sampled on every ce=1 edge while accumulating; a term is
//   consumed exactly when ce=1 and din_vld=1 in the accumulate state. ce=0
//   freezes both this block and the multiplier, so a stalled term is simply
//   presented again on the next enabled edge. dout_vld is likewise counted in
//   ce=1 edges: it stays high across ce=0 cycles and drops on the next ce=1.
interface adpcm_main_prod_accum_if #(
    parameter int din_WIDTH  = 44,
    parameter int dout_WIDTH = 32
);
    logic                         ce;
    logic                         start;
    logic signed [din_WIDTH-1:0]  din;
    logic                         din_vld;
    logic signed [dout_WIDTH-1:0] dout;
    logic                         dout_vld;
    logic                         busy;
    logic                         sat;

    modport master (
        output ce, start, din, din_vld,
        input  dout, dout_vld, busy, sat
    );

    modport slave (
        input  ce, start, din, din_vld,
        output dout, dout_vld, busy, sat
    );
endinterface

// File: rtl/adpcm_main_prod_accum.sv
// adpcm_main_prod_accum
//   Accumulates NUM_TERMS signed products from the pipelined multiplier into
//   a dot product for the ADPCM zero/pole predictors, arithmetic-right-shifts
//   the sum by SHIFT (floor rounding), saturates it to dout_WIDTH bits and
//   presents it with a one-cycle valid pulse.
//
//   Ports:
//     clk      rising-edge clock
//     reset    synchronous, active-high reset (applies regardless of ce)
//     bus      adpcm_main_prod_accum_if slave: ce/start/din/din_vld in,
//              dout/dout_vld/busy/sat out
//     o_state  current FSM state (0=IDLE, 1=ACC, 2=DONE) for observation
module adpcm_main_prod_accum #(
    parameter int ID         = 1,
    parameter int din_WIDTH  = 44,
    parameter int dout_WIDTH = 32,
    parameter int NUM_TERMS  = 6,
    parameter int SHIFT      = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    adpcm_main_prod_accum_if.slave  bus,
    output logic [1:0]              o_state
);

    // Four guard bits: sixteen full-scale terms cannot overflow.
    localparam int ACC_W = din_WIDTH + 4;
    localparam logic [3:0] LAST_CNT = 4'(NUM_TERMS - 1);

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - dout_WIDTH + 1){1'b1}}, {(dout_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                       r_state;
    logic signed [ACC_W-1:0]      r_acc;
    logic [3:0]                   r_cnt;
    logic signed [dout_WIDTH-1:0] r_dout;
    logic                         r_dout_vld;
    logic                         r_sat;

    state_t                       w_state_nxt;
    logic signed [ACC_W-1:0]      w_acc_nxt;
    logic [3:0]                   w_cnt_nxt;
    logic signed [dout_WIDTH-1:0] w_dout_nxt;
    logic                         w_dout_vld_nxt;
    logic                         w_sat_nxt;

    logic signed [ACC_W-1:0]      w_din_ext;
    logic signed [ACC_W-1:0]      w_shifted;
    logic signed [dout_WIDTH-1:0] w_clip;
    logic                         w_clip_sat;

    assign w_din_ext = {{(ACC_W - din_WIDTH){bus.din[din_WIDTH-1]}}, bus.din};

    // Signed >>> on a signed operand rounds toward -inf, which is the
    // rounding the predictor arithmetic expects.
    assign w_shifted = r_acc >>> SHIFT;

    always_comb begin
        w_clip     = w_shifted[dout_WIDTH-1:0];
        w_clip_sat = 1'b0;
        if (w_shifted > SAT_MAX) begin
            w_clip     = SAT_MAX[dout_WIDTH-1:0];
            w_clip_sat = 1'b1;
        end else if (w_shifted < SAT_MIN) begin
            w_clip     = SAT_MIN[dout_WIDTH-1:0];
            w_clip_sat = 1'b1;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_dout_nxt     = r_dout;
        w_sat_nxt      = r_sat;
        w_dout_vld_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (bus.din_vld) begin
                    w_acc_nxt = r_acc + w_din_ext;
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == LAST_CNT) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_dout_nxt     = w_clip;
                w_sat_nxt      = w_clip_sat;
                w_dout_vld_nxt = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Everything, including the dout_vld pulse, advances only on ce=1 edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_sat      <= 1'b0;
        end else if (bus.ce) begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dout     <= w_dout_nxt;
            r_dout_vld <= w_dout_vld_nxt;
            r_sat      <= w_sat_nxt;
        end
    end

    assign bus.dout     = r_dout;
    assign bus.dout_vld = r_dout_vld;
    assign bus.sat      = r_sat;
    assign bus.busy     = (r_state != S_IDLE);
    assign o_state      = r_state;

endmodule

// File: tb/tb_adpcm_main_prod_accum.sv
module tb_adpcm_main_prod_accum;

    localparam int DIN_W  = 44;
    localparam int DOUT_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic       clk;
    logic       reset;
    logic [1:0] o_state;
    int         total;
    int         bad;
    int         cyc;
    logic       mon_seen;

    // Expected {sat, dout} per result.
    logic [DOUT_W:0] exp_q[$];

    adpcm_main_prod_accum_if #(.din_WIDTH(DIN_W), .dout_WIDTH(DOUT_W)) bus ();

    adpcm_main_prod_accum #(
        .ID(1), .din_WIDTH(DIN_W), .dout_WIDTH(DOUT_W), .NUM_TERMS(6), .SHIFT(14)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .o_state(o_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [DOUT_W:0] model(input longint s);
        longint q;
        q = s >>> 14;
        if (q > 64'sd2147483647)
            return {1'b1, 32'h7FFF_FFFF};
        else if (q < -64'sd2147483648)
            return {1'b1, 32'h8000_0000};
        else
            return {1'b0, q[31:0]};
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Pops one expected entry per dout_vld pulse; a pulse held across ce=0
    // cycles is consumed once.
    initial mon_seen = 1'b0;
    always @(negedge clk) begin
        if (!reset && bus.dout_vld && !mon_seen) begin
            logic [DOUT_W:0] e;
            mon_seen = 1'b1;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_vld observed=%0h expected=none", {bus.sat, bus.dout});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                assert ({bus.sat, bus.dout} === e) else begin
                    bad++;
                    $error("FAIL result observed=%0h expected=%0h", {bus.sat, bus.dout}, e);
                end
            end
        end
        if (!bus.dout_vld) mon_seen = 1'b0;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic term(input longint v);
        bus.din     = v[DIN_W-1:0];
        bus.din_vld = 1'b1;
        tick();
        bus.din_vld = 1'b0;
        bus.din     = '0;
    endtask

    task automatic wait_vld(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.dout_vld && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, bus.dout_vld}, 64'd1);
    endtask

    task automatic run_const(input string tag, input longint v);
        exp_q.push_back(model(v * 6));
        start_pulse();
        repeat (6) term(v);
        wait_vld(tag, 4);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        longint vals[6];
        longint sum;
        int c1;
        int c2;

        total = 0;
        bad   = 0;
        bus.ce      = 1'b1;
        bus.start   = 1'b0;
        bus.din     = '0;
        bus.din_vld = 1'b0;
        reset       = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_dout",  {32'd0, bus.dout}, 64'd0);
        chk("rst_vld",   {63'd0, bus.dout_vld}, 64'd0);
        chk("rst_busy",  {63'd0, bus.busy}, 64'd0);
        chk("rst_sat",   {63'd0, bus.sat}, 64'd0);
        chk("rst_state", {62'd0, o_state}, {62'd0, ST_IDLE});
        reset = 1'b0;
        tick();

        // Normal sum with latency checks: 6 * (1<<14) >>> 14 = 6
        exp_q.push_back(model(6 * 16384));
        start_pulse();
        chk("busy_acc", {63'd0, bus.busy}, 64'd1);
        repeat (6) term(16384);
        chk("lat_early_vld", {63'd0, bus.dout_vld}, 64'd0);
        chk("done_state", {62'd0, o_state}, {62'd0, ST_DONE});
        chk("busy_done", {63'd0, bus.busy}, 64'd1);
        tick();
        chk("lat_vld", {63'd0, bus.dout_vld}, 64'd1);
        chk("norm_dout", {32'd0, bus.dout}, 64'd6);
        chk("busy_after", {63'd0, bus.busy}, 64'd0);
        tick();
        chk("vld_pulse_clear", {63'd0, bus.dout_vld}, 64'd0);
        chk("dout_hold", {32'd0, bus.dout}, 64'd6);

        // Floor rounding and saturation
        run_const("floor_neg", -64'sd1);
        chk("floor_neg_dout", {32'd0, bus.dout}, {32'd0, 32'hFFFF_FFFF});
        run_const("floor_pos", 64'sd1);
        run_const("sat_neg", -(64'sd1 <<< 43));
        chk("sat_neg_flag", {63'd0, bus.sat}, 64'd1);
        run_const("sat_pos", (64'sd1 <<< 43) - 64'sd1);
        chk("sat_pos_dout", {32'd0, bus.dout}, {32'd0, 32'h7FFF_FFFF});

        // Stall and bubbles
        for (int i = 0; i < 6; i++) vals[i] = longint'(i + 1) * 20000 + 7;
        sum = 0;
        for (int i = 0; i < 6; i++) sum += vals[i];
        exp_q.push_back(model(sum));
        start_pulse();
        term(vals[0]);
        term(vals[1]);
        repeat (3) tick();
        term(vals[2]);
        bus.ce = 1'b0;
        bus.din = 44'd999999;
        bus.din_vld = 1'b1;
        repeat (2) tick();
        bus.din_vld = 1'b0;
        bus.ce = 1'b1;
        term(vals[3]);
        term(vals[4]);
        term(vals[5]);
        tick();
        chk("stall_vld", {63'd0, bus.dout_vld}, 64'd1);
        bus.ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_vld_hold", {63'd0, bus.dout_vld}, 64'd1);
        end
        bus.ce = 1'b1;
        tick();
        chk("stall_vld_clear", {63'd0, bus.dout_vld}, 64'd0);

        // Protocol misuse: din_vld in IDLE/DONE and start in ACC ignored
        for (int i = 0; i < 6; i++) vals[i] = longint'(i + 1) * 50000;
        sum = 0;
        for (int i = 0; i < 6; i++) sum += vals[i];
        exp_q.push_back(model(sum));
        bus.din = 44'd1 << 40;
        bus.din_vld = 1'b1;
        repeat (2) tick();
        bus.din_vld = 1'b0;
        start_pulse();
        term(vals[0]);
        bus.start = 1'b1;
        term(vals[1]);
        bus.start = 1'b0;
        chk("misuse_state_acc", {62'd0, o_state}, {62'd0, ST_ACC});
        for (int i = 2; i < 6; i++) term(vals[i]);
        chk("misuse_state_done", {62'd0, o_state}, {62'd0, ST_DONE});
        bus.din = 44'd1 << 40;
        bus.din_vld = 1'b1;
        tick();
        bus.din_vld = 1'b0;
        bus.din = '0;
        chk("misuse_vld", {63'd0, bus.dout_vld}, 64'd1);
        chk("misuse_dout", {32'd0, bus.dout}, 64'd64);
        tick();

        // Reset mid-operation
        start_pulse();
        repeat (3) term(16384);
        chk("mid_busy", {63'd0, bus.busy}, 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_dout",  {32'd0, bus.dout}, 64'd0);
        chk("mid_rst_vld",   {63'd0, bus.dout_vld}, 64'd0);
        chk("mid_rst_busy",  {63'd0, bus.busy}, 64'd0);
        chk("mid_rst_sat",   {63'd0, bus.sat}, 64'd0);
        chk("mid_rst_state", {62'd0, o_state}, {62'd0, ST_IDLE});
        reset = 1'b0;
        repeat (10) tick();
        chk("mid_no_vld", {63'd0, bus.dout_vld}, 64'd0);
        run_const("after_rst", longint'(3) <<< 14);
        chk("after_rst_dout", {32'd0, bus.dout}, 64'd18);

        // Back-to-back: start in the dout_vld cycle
        exp_q.push_back(model(6 * (longint'(5) <<< 14)));
        exp_q.push_back(model(6 * (longint'(7) <<< 14)));
        start_pulse();
        repeat (6) term(longint'(5) <<< 14);
        tick();
        chk("b2b_vld1", {63'd0, bus.dout_vld}, 64'd1);
        c1 = cyc;
        start_pulse();
        repeat (6) term(longint'(7) <<< 14);
        tick();
        chk("b2b_vld2", {63'd0, bus.dout_vld}, 64'd1);
        c2 = cyc;
        chk("b2b_spacing", 64'(c2 - c1), 64'd8);
        chk("b2b_dout2", {32'd0, bus.dout}, 64'd42);
        tick();

        repeat (3) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
